// File: rtl/vga_sync_gen.sv
// Pixel-rate timing generator for a 640x480@60 VGA DAC: clock divider, x/y raster counters
// and registered sync/blank decode, all changing together on the pix_en cycle.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_en,
  output logic             vga_clk,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank,
  output logic             vga_sync,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             pix_en_q, pix_en_d;
  logic             vga_clk_q, vga_clk_d;
  logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic             tick;

  always_comb begin
    tick          = (div_q == DIV_LAST);
    div_d         = tick ? '0 : div_q + 1'b1;
    x_d           = x_q;
    y_d           = y_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_d       = blank_q;
    pix_en_d      = tick;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    // Low for the first half of each pixel period, so it falls together with pix_en.
    vga_clk_d     = (div_d >= DIV_HALF);

    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      // Decode from the new position so outputs stay aligned with x/y.
      blank_d       = (x_d < X_ACT) && (y_d < Y_ACT);
      hs_d          = !((x_d >= HS_BEG) && (x_d < HS_END));
      vs_d          = !((y_d >= VS_BEG) && (y_d < VS_END));
      line_start_d  = (x_d == '0);
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_en_q      <= pix_en_d;
      vga_clk_q     <= vga_clk_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign vga_clk     = vga_clk_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank   = blank_q;
  assign vga_sync    = 1'b0;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance plus a tiny-raster instance for full frames,
// both checked every clock against a pixel-index model, with literal timing pins.
module tb_vga_sync_gen;

  localparam int W_A = 10;
  localparam int CD_B = 4, HA_B = 10, HF_B = 2, HS_B = 3, HB_B = 2;
  localparam int VA_B = 6, VF_B = 2, VS_B = 2, VB_B = 3, W_B = 5;

  typedef struct packed {
    logic        pix_en;
    logic        vga_clk;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        sync;
    logic        ls;
    logic        fs;
    logic [15:0] x;
    logic [15:0] y;
  } vid_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a = 1'b1, reset_b = 1'b1;
  logic pix_en_a, vga_clk_a, hs_a, vs_a, blank_a, sync_a, ls_a, fs_a;
  logic pix_en_b, vga_clk_b, hs_b, vs_b, blank_b, sync_b, ls_b, fs_b;
  logic [W_A-1:0] x_a, y_a;
  logic [W_B-1:0] x_b, y_b;

  int     errors = 0, checks = 0;
  logic   chk_en = 1'b0;
  longint cyc = 0, n_a = 0, n_b = 0;

  vga_sync_gen dut_a (
    .clk(clk), .reset(reset_a), .pix_en(pix_en_a), .vga_clk(vga_clk_a), .vga_hs(hs_a),
    .vga_vs(vs_a), .vga_blank(blank_a), .vga_sync(sync_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .CLK_DIV(CD_B), .H_ACTIVE(HA_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
    .V_ACTIVE(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B), .CNT_W(W_B)
  ) dut_b (
    .clk(clk), .reset(reset_b), .pix_en(pix_en_b), .vga_clk(vga_clk_b), .vga_hs(hs_b),
    .vga_vs(vs_b), .vga_blank(blank_b), .vga_sync(sync_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  // n = clocks since reset was last sampled high; everything follows from pixel index n/cd.
  function automatic vid_t model(input longint n, input int cd, input int ha, input int hf,
                                 input int hsw, input int hb, input int va, input int vf,
                                 input int vsw, input int vb);
    vid_t   m;
    longint ht, vt, k, p, xx, yy;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    m = '0;
    m.pix_en  = (n > 0) && (n % cd == 0);
    m.vga_clk = (n % cd) >= (cd / 2);
    k = n / cd;
    if (k == 0) begin
      xx = ht - 1;
      yy = vt - 1;
      m.hs = 1'b1;
      m.vs = 1'b1;
    end else begin
      p  = (k - 1) % (ht * vt);
      xx = p % ht;
      yy = p / ht;
      m.blank = (xx < ha) && (yy < va);
      m.hs    = !((xx >= ha + hf) && (xx < ha + hf + hsw));
      m.vs    = !((yy >= va + vf) && (yy < va + vf + vsw));
      m.ls    = m.pix_en && (xx == 0);
      m.fs    = m.pix_en && (p == 0);
    end
    m.x = 16'(xx);
    m.y = 16'(yy);
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      if (errors >= 100) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    n_a <= reset_a ? 0 : n_a + 1;
    n_b <= reset_b ? 0 : n_b + 1;
  end

  vid_t act_a, act_b;
  assign act_a = {pix_en_a, vga_clk_a, hs_a, vs_a, blank_a, sync_a, ls_a, fs_a,
                  16'(x_a), 16'(y_a)};
  assign act_b = {pix_en_b, vga_clk_b, hs_b, vs_b, blank_b, sync_b, ls_b, fs_b,
                  16'(x_b), 16'(y_b)};

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_a", 64'(act_a), 64'(model(n_a, 2, 640, 16, 96, 48, 480, 10, 2, 33)));
      check("cycle_b", 64'(act_b),
            64'(model(n_b, CD_B, HA_B, HF_B, HS_B, HB_B, VA_B, VF_B, VS_B, VB_B)));
    end
  end

  task automatic check_reset_a(input string tag);
    check({tag, "_x"}, 64'(x_a), 799);
    check({tag, "_y"}, 64'(y_a), 524);
    check({tag, "_hs"}, 64'(hs_a), 1);
    check({tag, "_vs"}, 64'(vs_a), 1);
    check({tag, "_blank"}, 64'(blank_a), 0);
    check({tag, "_vga_clk"}, 64'(vga_clk_a), 0);
    check({tag, "_pix_en"}, 64'(pix_en_a), 0);
    check({tag, "_ls"}, 64'(ls_a), 0);
    check({tag, "_fs"}, 64'(fs_a), 0);
  endtask

  task automatic check_first_pix_a(input string tag);
    @(negedge clk);
    check({tag, "_pix_en_early"}, 64'(pix_en_a), 0);
    check({tag, "_vga_clk_high"}, 64'(vga_clk_a), 1);
    @(negedge clk);
    check({tag, "_pix_en"}, 64'(pix_en_a), 1);
    check({tag, "_vga_clk_low"}, 64'(vga_clk_a), 0);
    check({tag, "_x"}, 64'(x_a), 0);
    check({tag, "_y"}, 64'(y_a), 0);
    check({tag, "_blank"}, 64'(blank_a), 1);
    check({tag, "_ls"}, 64'(ls_a), 1);
    check({tag, "_fs"}, 64'(fs_a), 1);
  endtask

  initial begin
    longint    t0;
    int        hs_pix, hs_clk, hs_first, bl_cnt, vs_pix;
    bit        found;
    logic [1:0] sel;

    repeat (5) @(negedge clk);
    chk_en = 1'b1;
    check_reset_a("rst");
    check("rst_sync", 64'(sync_a), 0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    check_first_pix_a("rel");

    // One full line of the default raster.
    t0 = cyc; hs_pix = 0; hs_clk = 0; hs_first = -1; bl_cnt = int'(blank_a); found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pix_en_a && ls_a) begin
        found = 1;
        break;
      end
      if (!hs_a) hs_clk++;
      if (pix_en_a && !hs_a) begin
        if (hs_pix == 0) hs_first = int'(x_a);
        hs_pix++;
      end
      if (pix_en_a && blank_a) bl_cnt++;
    end
    check("line_found", 64'(found), 1);
    check("line_period", 64'(cyc - t0), 1600);
    check("hs_low_pixels", 64'(hs_pix), 96);
    check("hs_low_clks", 64'(hs_clk), 192);
    check("hs_first_x", 64'(hs_first), 656);
    check("blank_pixels_line0", 64'(bl_cnt), 640);

    // Line wrap at x=799 on line 1.
    found = 0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      if (pix_en_a && x_a == 10'd799) begin
        found = 1;
        break;
      end
    end
    check("wrap_found", 64'(found), 1);
    check("wrap_pre_y", 64'(y_a), 1);
    @(negedge clk);
    @(negedge clk);
    check("wrap_x", 64'(x_a), 0);
    check("wrap_y", 64'(y_a), 2);
    check("wrap_ls", 64'(ls_a), 1);
    check("wrap_fs", 64'(fs_a), 0);

    // Mid-frame reset at x=300, y=2.
    found = 0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      if (pix_en_a && x_a == 10'd300 && y_a == 10'd2) begin
        found = 1;
        break;
      end
    end
    check("mid_found", 64'(found), 1);
    reset_a = 1'b1;
    @(negedge clk);
    check_reset_a("mid");
    reset_a = 1'b0;
    check_first_pix_a("mid_rel");
    t0 = cyc; found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pix_en_a && ls_a) begin
        found = 1;
        break;
      end
    end
    check("resume_found", 64'(found), 1);
    check("resume_period", 64'(cyc - t0), 1600);
    check("resume_y", 64'(y_a), 1);

    // Two full frames on the small raster: 17x13 pixels, 4 clk per pixel.
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (pix_en_b && fs_b) begin
        found = 1;
        break;
      end
    end
    check("b_fs_found", 64'(found), 1);
    for (int f = 0; f < 2; f++) begin
      t0 = cyc; vs_pix = 0; bl_cnt = int'(blank_b); found = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (pix_en_b && fs_b) begin
          found = 1;
          break;
        end
        if (pix_en_b && !vs_b) vs_pix++;
        if (pix_en_b && blank_b) bl_cnt++;
      end
      check("b_frame_found", 64'(found), 1);
      check("b_frame_period", 64'(cyc - t0), 884);
      check("b_vs_low_pixels", 64'(vs_pix), 34);
      check("b_blank_pixels", 64'(bl_cnt), 60);
    end

    // Random reset pulses; the per-cycle model tracks recovery.
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(1, 1500)) @(negedge clk);
      sel = 2'($urandom_range(1, 3));
      reset_a = sel[0];
      reset_b = sel[1];
      repeat ($urandom_range(1, 4)) @(negedge clk);
      reset_a = 1'b0;
      reset_b = 1'b0;
    end
    repeat (2000) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
